// File: rtl/vote_ballot_ctrl_if.sv
// Ballot front-end bus: officer arm and raw buttons in, vote pulses, status and ballot count out.
interface vote_ballot_ctrl_if #(
  parameter int CNT_W = 21
);
  logic             arm;
  logic [3:0]       btn;
  logic             a;
  logic             b;
  logic             c;
  logic             d;
  logic             ready;
  logic             multi_err;
  logic             timeout;
  logic [CNT_W-1:0] ballots;

  modport master (
    output arm, btn,
    input  a, b, c, d, ready, multi_err, timeout, ballots
  );

  modport slave (
    input  arm, btn,
    output a, b, c, d, ready, multi_err, timeout, ballots
  );
endinterface

// File: rtl/vote_ballot_ctrl.sv
// Ballot front end: synchronises/debounces candidate buttons, gates them with officer arm, one pulse per ballot.
// Optional ballot expiry is enabled by defining BALLOT_TIMEOUT_EN.
module vote_ballot_ctrl #(
  parameter int DB_CYCLES      = 16,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 21
) (
  input logic              clk,
  input logic              rst,
  vote_ballot_ctrl_if.slave bus
);

  localparam int DBW = $clog2(DB_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, ARMED, CAST, REJECT, RELEASE} state_t;

  state_t           state, nxt;
  logic [1:0]       arm_sync;
  logic             arm_prev;
  logic [3:0]       btn_s1, btn_s2, db;
  logic [DBW-1:0]   dcnt [4];
  logic [3:0]       cand;
  logic [3:0]       pulse;
  logic             ready_q, multi_q, multi_nxt;
  logic [CNT_W-1:0] ballots_q;
  logic             arm_rise, one_hot, multi;

  assign arm_rise = arm_sync[1] & ~arm_prev;
  assign one_hot  = (db != '0) && ((db & (db - 4'd1)) == '0);
  assign multi    = (db != '0) && !one_hot;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arm_sync <= '0;
      arm_prev <= 1'b0;
      btn_s1   <= '0;
      btn_s2   <= '0;
      db       <= '0;
      for (int unsigned i = 0; i < 4; i++) dcnt[i] <= '0;
    end else begin
      arm_sync <= {arm_sync[0], bus.arm};
      arm_prev <= arm_sync[1];
      btn_s1   <= bus.btn;
      btn_s2   <= btn_s1;
      for (int unsigned i = 0; i < 4; i++) begin
        if (btn_s2[i] == db[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DBW'(DB_CYCLES - 1)) begin
          db[i]   <= btn_s2[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef BALLOT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tcnt;
  logic          t_live, t_exp, tmo_nxt, tmo_q;

  assign t_live = (state == ARMED) || (state == REJECT);
  assign t_exp  = t_live && (tcnt == TW'(TIMEOUT_CYCLES - 1));

  // REJECT->ARMED is also an entry to ARMED, so the window restarts there.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt  <= '0;
      tmo_q <= 1'b0;
    end else begin
      tmo_q <= tmo_nxt;
      if (nxt == ARMED && state != ARMED) tcnt <= '0;
      else if (t_live && !t_exp)          tcnt <= tcnt + 1'b1;
    end
  end

  assign bus.timeout = tmo_q;
`else
  assign bus.timeout = 1'b0;
`endif

  always_comb begin
    nxt       = state;
    multi_nxt = 1'b0;
`ifdef BALLOT_TIMEOUT_EN
    tmo_nxt   = 1'b0;
`endif
    case (state)
      IDLE: if (arm_rise && db == '0) nxt = ARMED;
      ARMED: begin
        // A cast decided in the expiry cycle takes precedence over the timeout.
        if (one_hot) begin
          nxt = CAST;
`ifdef BALLOT_TIMEOUT_EN
        end else if (t_exp) begin
          nxt     = IDLE;
          tmo_nxt = 1'b1;
`endif
        end else if (multi) begin
          nxt       = REJECT;
          multi_nxt = 1'b1;
        end
      end
      CAST: nxt = RELEASE;
      REJECT: begin
`ifdef BALLOT_TIMEOUT_EN
        if (t_exp) begin
          nxt     = RELEASE;
          tmo_nxt = 1'b1;
        end else
`endif
        if (db == '0) nxt = ARMED;
      end
      RELEASE: if (db == '0) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cand      <= '0;
      pulse     <= '0;
      ready_q   <= 1'b0;
      multi_q   <= 1'b0;
      ballots_q <= '0;
    end else begin
      state   <= nxt;
      ready_q <= (nxt == ARMED);
      multi_q <= multi_nxt;
      pulse   <= (state == CAST) ? cand : '0;
      if (state == ARMED && one_hot) cand <= db;
      if (state == CAST && ballots_q != '1) ballots_q <= ballots_q + 1'b1;
    end
  end

  assign bus.a         = pulse[0];
  assign bus.b         = pulse[1];
  assign bus.c         = pulse[2];
  assign bus.d         = pulse[3];
  assign bus.ready     = ready_q;
  assign bus.multi_err = multi_q;
  assign bus.ballots   = ballots_q;

endmodule

// File: tb/tb_vote_ballot_ctrl.sv
// Self-checking bench for vote_ballot_ctrl: directed scenarios followed by randomized ballots against a vote-tally model.
module tb_vote_ballot_ctrl;

  localparam int DB = 4;
  localparam int TO = 50;
  localparam int W  = 21;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  vote_ballot_ctrl_if #(.CNT_W(W)) bus ();

  vote_ballot_ctrl #(
    .DB_CYCLES     (DB),
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Observed event tallies
  int seen [4] = '{default: 0};
  int seen_multi   = 0;
  int seen_tmo     = 0;
  int seen_overlap = 0;

  // Expected tallies derived from the ballots the bench casts
  int exp_cnt [4] = '{default: 0};
  int exp_b     = 0;
  int exp_multi = 0;
  int exp_tmo   = 0;

  always @(negedge clk) begin
    if (rst) begin
      if (bus.a) seen[0]++;
      if (bus.b) seen[1]++;
      if (bus.c) seen[2]++;
      if (bus.d) seen[3]++;
      if (bus.multi_err) seen_multi++;
      if (bus.timeout)   seen_tmo++;
      if ($countones({bus.a, bus.b, bus.c, bus.d}) > 1) seen_overlap++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_cnt%0d", tag, i), 32'(seen[i]), 32'(exp_cnt[i]));
    check({tag, "_ballots"}, 32'(bus.ballots), 32'(exp_b));
    check({tag, "_multi"},   32'(seen_multi),  32'(exp_multi));
    check({tag, "_tmo"},     32'(seen_tmo),    32'(exp_tmo));
  endtask

  task automatic open_ballot();
    bus.arm = 1'b0;
    tick(4);
    bus.arm = 1'b1;
    tick(4);
  endtask

  task automatic press(input logic [3:0] mask, input int hold);
    bus.btn = mask;
    tick(hold);
    bus.btn = '0;
    tick(DB + 4);
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.a, bus.b, bus.c, bus.d, bus.ready, bus.multi_err, bus.timeout});
  endfunction

  initial begin
    int first, n, cand, glitches, bitn;
    logic [3:0] m;

    // Reset with every input asserted
    rst     = 1'b0;
    bus.btn = 4'hF;
    bus.arm = 1'b1;
    tick(3);
    check("rst_outs", outs(), 32'd0);
    check("rst_ballots", 32'(bus.ballots), 32'd0);
    bus.btn = '0;
    bus.arm = 1'b0;
    tick(1);
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      check("post_rst_outs", outs(), 32'd0);
    end

    // Single vote for C: latency and width
    open_ballot();
    check("single_ready", 32'(bus.ready), 32'd1);
    bus.btn = 4'b0100;
    first = -1;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (bus.c) begin
        n++;
        if (first < 0) first = k;
      end
    end
    check("single_latency", 32'(first), 32'd8);
    check("single_width", 32'(n), 32'd1);
    check("single_ready_fall", 32'(bus.ready), 32'd0);
    bus.btn = '0;
    tick(DB + 4);
    exp_cnt[2]++;
    exp_b++;
    check_model("single");

    // Bounce shorter than the debounce window
    open_ballot();
    for (int k = 0; k < 10; k++) begin
      bus.btn[0] = ~bus.btn[0];
      tick(2);
    end
    bus.btn = '0;
    tick(10);
    check("bounce_ready", 32'(bus.ready), 32'd1);
    check_model("bounce");

    // Simultaneous A+B is rejected, then D votes in the same ballot
    bus.btn = 4'b0011;
    tick(12);
    exp_multi++;
    check_model("multi");
    check("multi_ready", 32'(bus.ready), 32'd0);
    bus.btn = '0;
    tick(DB + 4);
    check("multi_rearmed", 32'(bus.ready), 32'd1);
    press(4'b1000, 12);
    exp_cnt[3]++;
    exp_b++;
    check_model("multi_d");

    // Held button across a re-arm never votes twice
    open_ballot();
    bus.btn = 4'b0001;
    tick(12);
    bus.arm = 1'b0;
    tick(4);
    bus.arm = 1'b1;
    tick(4);
    exp_cnt[0]++;
    exp_b++;
    check_model("held");
    bus.btn = '0;
    tick(DB + 4);
    check("held_idle", 32'(bus.ready), 32'd0);
    open_ballot();
    check("revote_ready", 32'(bus.ready), 32'd1);
    press(4'b0001, 12);
    exp_cnt[0]++;
    exp_b++;
    check_model("revote");

    // Button held in IDLE blocks arming
    bus.btn = 4'b0010;
    tick(DB + 4);
    open_ballot();
    check("idle_held_ready", 32'(bus.ready), 32'd0);
    bus.btn = '0;
    tick(DB + 4);
    check_model("idle_held");

    // Ballot left unattended
    open_ballot();
    tick(TO + 10);
`ifdef BALLOT_TIMEOUT_EN
    exp_tmo++;
    check("timeout_ready", 32'(bus.ready), 32'd0);
`else
    check("no_timeout_ready", 32'(bus.ready), 32'd1);
`endif
    check_model("timeout");

    // Randomized ballots with short glitches and occasional multi-presses
    for (int it = 0; it < 12; it++) begin
      open_ballot();
      check("rnd_ready", 32'(bus.ready), 32'd1);
      glitches = $urandom_range(0, 3);
      for (int g = 0; g < glitches; g++) begin
        bitn = $urandom_range(0, 3);
        bus.btn = 4'(1 << bitn);
        tick($urandom_range(1, 3));
        bus.btn = '0;
        tick($urandom_range(1, 3));
      end
      if ($urandom_range(0, 4) == 0) begin
        do m = 4'($urandom_range(3, 15)); while ($countones(m) < 2);
        press(m, 10);
        exp_multi++;
      end
      cand = $urandom_range(0, 3);
      press(4'(1 << cand), $urandom_range(8, 15));
      exp_cnt[cand]++;
      exp_b++;
      check_model("rnd");
    end

    check("pulse_overlap", 32'(seen_overlap), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
